// File: rtl/conv1d_ctrl_pkg.sv
// Shared types and constants for the conv1d sequencer.
package conv1d_ctrl_pkg;

    localparam int unsigned NumWords  = 128;
    localparam int unsigned AddrWidth = $clog2(NumWords);
    localparam int unsigned MaxKernel = 8;
    localparam int unsigned KLenW     = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_K,
        CONV_RD,
        CONV_WR,
        DONE
    } state_e;

    typedef struct packed {
        logic [AddrWidth-1:0] in_base;
        logic [AddrWidth:0]   in_len;
        logic [AddrWidth-1:0] k_base;
        logic [KLenW-1:0]     k_len;
        logic [AddrWidth-1:0] out_base;
    } cfg_t;

endpackage

// File: rtl/conv1d_ctrl_if.sv
// Single-port SRAM bus between the conv1d sequencer (master) and the SRAM mux (slave).
interface conv1d_ctrl_if;
    import conv1d_ctrl_pkg::*;

    logic                 req;
    logic                 we;
    logic [AddrWidth-1:0] addr;
    logic [31:0]          wdata;
    logic [31:0]          rdata;

    modport master (output req, we, addr, wdata, input rdata);
    modport slave  (input req, we, addr, wdata, output rdata);

endinterface

// File: rtl/conv1d_mac.sv
// Registered 32-bit accumulator with combinational acc + a*b sum output.
module conv1d_mac (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] sum_o
);

    logic [31:0] acc_q, acc_d, prod;

    // Low 32 bits of a signed and an unsigned 32x32 product are identical.
    always_comb begin
        prod  = a_i * b_i;
        sum_o = acc_q + prod;
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = sum_o;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/conv1d_ctrl.sv
// conv1d sequencer: kernel load, MAC streaming and write-back over the internal SRAM.
// Optional build macro CONV1D_RELU_EN clamps negative results to zero on write-back.
module conv1d_ctrl #(
    parameter int unsigned NumWords  = 128,
    parameter int unsigned AddrWidth = $clog2(NumWords),
    parameter int unsigned MaxKernel = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [AddrWidth-1:0] in_base_i,
    input  logic [AddrWidth:0]   in_len_i,
    input  logic [AddrWidth-1:0] k_base_i,
    input  logic [3:0]           k_len_i,
    input  logic [AddrWidth-1:0] out_base_i,
    conv1d_ctrl_if.master        mem,
    output logic                 ext_gnt_o,
    output logic                 running_o,
    output logic                 running_e_o,
    output logic                 done_o,
    output logic                 done_e_o,
    output logic                 err_o
);
    import conv1d_ctrl_pkg::*;

    localparam int unsigned TapW = $clog2(MaxKernel);

    state_e          state_q, state_d;
    cfg_t            cfg_q, cfg_d;
    logic [TapW-1:0] tap_q, tap_d, ld_idx_q, ld_idx_d, rd_idx_q, rd_idx_d;
    logic [AddrWidth-1:0] j_q, j_d;
    logic            ld_q, ld_d, rd_q, rd_d;
    logic [31:0]     kern_q [MaxKernel];
    logic [31:0]     kern_d [MaxKernel];
    logic            err_q, err_d, done_e_q, done_e_d, run_e_q, run_e_d;

    logic            accept, cfg_ok, last_tap, last_j, busy;
    logic [31:0]     kl, nl, mac_sum, result;

    assign kl = 32'(k_len_i);
    assign nl = 32'(in_len_i);
    assign cfg_ok = (kl >= 32'd1) && (kl <= MaxKernel) && (kl <= nl)
                 && (32'(in_base_i) + nl <= NumWords)
                 && (32'(k_base_i) + kl <= NumWords)
                 && (32'(out_base_i) + nl - kl + 32'd1 <= NumWords);

    assign accept   = start_i && (state_q == IDLE || state_q == DONE);
    assign last_tap = (tap_q == TapW'(cfg_q.k_len - 4'd1));
    // M-1 = N-K, the index of the final output word.
    assign last_j   = (j_q == AddrWidth'(cfg_q.in_len - (AddrWidth+1)'(cfg_q.k_len)));
    assign busy     = (state_q == LOAD_K) || (state_q == CONV_RD) || (state_q == CONV_WR);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: if (accept) state_d = cfg_ok ? LOAD_K : DONE;
            LOAD_K:     if (last_tap) state_d = CONV_RD;
            CONV_RD:    if (last_tap) state_d = CONV_WR;
            CONV_WR:    state_d = last_j ? DONE : CONV_RD;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        cfg_d    = cfg_q;
        tap_d    = tap_q;
        j_d      = j_q;
        ld_d     = (state_q == LOAD_K);
        ld_idx_d = tap_q;
        rd_d     = (state_q == CONV_RD);
        rd_idx_d = tap_q;
        kern_d   = kern_q;
        err_d    = err_q;
        run_e_d  = accept && cfg_ok;
        done_e_d = (state_d == DONE) && (state_q != DONE || accept);
        if (ld_q) kern_d[ld_idx_q] = mem.rdata;
        if (accept) begin
            cfg_d = '{in_base: in_base_i, in_len: in_len_i, k_base: k_base_i,
                      k_len: k_len_i, out_base: out_base_i};
            tap_d = '0;
            j_d   = '0;
            err_d = !cfg_ok;
        end
        unique case (state_q)
            LOAD_K, CONV_RD: tap_d = last_tap ? '0 : tap_q + TapW'(1);
            CONV_WR: begin
                tap_d = '0;
                j_d   = j_q + AddrWidth'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cfg_q    <= '0;
            tap_q    <= '0;
            j_q      <= '0;
            ld_q     <= 1'b0;
            ld_idx_q <= '0;
            rd_q     <= 1'b0;
            rd_idx_q <= '0;
            err_q    <= 1'b0;
            done_e_q <= 1'b0;
            run_e_q  <= 1'b0;
            for (int unsigned i = 0; i < MaxKernel; i++) kern_q[i] <= '0;
        end else begin
            cfg_q    <= cfg_d;
            tap_q    <= tap_d;
            j_q      <= j_d;
            ld_q     <= ld_d;
            ld_idx_q <= ld_idx_d;
            rd_q     <= rd_d;
            rd_idx_q <= rd_idx_d;
            err_q    <= err_d;
            done_e_q <= done_e_d;
            run_e_q  <= run_e_d;
            kern_q   <= kern_d;
        end
    end

    // The write cycle folds in the product of the final tap read.
    conv1d_mac u_mac (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (state_q == CONV_WR),
        .en_i   (rd_q),
        .a_i    (mem.rdata),
        .b_i    (kern_q[rd_idx_q]),
        .sum_o  (mac_sum)
    );

    always_comb begin
        result = mac_sum;
`ifdef CONV1D_RELU_EN
        if (mac_sum[31]) result = '0;
`endif
        mem.req     = busy;
        mem.we      = (state_q == CONV_WR);
        mem.wdata   = (state_q == CONV_WR) ? result : '0;
        mem.addr    = '0;
        unique case (state_q)
            LOAD_K:  mem.addr = cfg_q.k_base + AddrWidth'(tap_q);
            CONV_RD: mem.addr = cfg_q.in_base + j_q + AddrWidth'(tap_q);
            CONV_WR: mem.addr = cfg_q.out_base + j_q;
            default: ;
        endcase
        ext_gnt_o   = !busy;
        running_o   = busy;
        running_e_o = run_e_q;
        done_o      = (state_q == DONE);
        done_e_o    = done_e_q;
        err_o       = err_q;
    end

endmodule

// File: tb/tb_conv1d_ctrl.sv
// Self-checking bench for conv1d_ctrl: SRAM model plus an arithmetic reference of the convolution.
module tb_conv1d_ctrl;

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic       start_i = 1'b0;
    logic [6:0] in_base_i = '0, k_base_i = '0, out_base_i = '0;
    logic [7:0] in_len_i = '0;
    logic [3:0] k_len_i = '0;
    logic       ext_gnt_o, running_o, running_e_o, done_o, done_e_o, err_o;

    conv1d_ctrl_if mem_if ();

    conv1d_ctrl #(.NumWords(128), .AddrWidth(7), .MaxKernel(8)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .in_base_i   (in_base_i),
        .in_len_i    (in_len_i),
        .k_base_i    (k_base_i),
        .k_len_i     (k_len_i),
        .out_base_i  (out_base_i),
        .mem         (mem_if),
        .ext_gnt_o   (ext_gnt_o),
        .running_o   (running_o),
        .running_e_o (running_e_o),
        .done_o      (done_o),
        .done_e_o    (done_e_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    logic [31:0] sram [128];
    logic        pl_we = 1'b0;
    logic [6:0]  pl_addr = '0;
    logic [31:0] pl_data = '0;

    always @(posedge clk) begin
        if (pl_we) sram[pl_addr] <= pl_data;
        else if (mem_if.req) begin
            if (mem_if.we) sram[mem_if.addr] <= mem_if.wdata;
            else mem_if.rdata <= sram[mem_if.addr];
        end
    end

    int n_chk = 0, n_fail = 0;
    int vin [256];
    int vk [8];
    int exp_out [128];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int ref_out(int j, int k);
        int s = 0;
        for (int i = 0; i < k; i++) s += vin[j+i] * vk[i];
`ifdef CONV1D_RELU_EN
        if (s < 0) s = 0;
`endif
        return s;
    endfunction

    task automatic load_mem(int ib, int n, int kb, int k);
        for (int i = 0; i < n + k; i++) begin
            @(negedge clk);
            pl_we   = 1'b1;
            pl_addr = (i < n) ? 7'(ib + i) : 7'(kb + i - n);
            pl_data = (i < n) ? vin[i] : vk[i-n];
        end
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    task automatic wait_done(string tag, output int lat);
        lat = 0;
        for (int c = 1; c <= 3000; c++) begin
            @(negedge clk);
            if (done_e_o) begin lat = c; break; end
        end
        chk({tag, "/done_seen"}, 32'(lat != 0), 32'd1);
    endtask

    task automatic run_job(string tag, int ib, int n, int kb, int k, int ob, bit hold);
        bit valid;
        int m, t_exp, lat, gnt_low, reqs, re_cnt;
        m = n - k + 1;
        valid = (k >= 1) && (k <= 8) && (k <= n) && (ib + n <= 128) && (kb + k <= 128) && (ob + m <= 128);
        t_exp = valid ? k + m * (k + 1) + 1 : 1;
        if (valid) for (int j = 0; j < m; j++) exp_out[j] = ref_out(j, k);
        @(negedge clk);
        in_base_i = 7'(ib); in_len_i = 8'(n); k_base_i = 7'(kb); k_len_i = 4'(k); out_base_i = 7'(ob);
        start_i = 1'b1;
        lat = 0; gnt_low = 0; reqs = 0; re_cnt = 0;
        for (int c = 1; c <= 3000; c++) begin
            @(negedge clk);
            if (c == 1) begin
                if (!hold) begin
                    start_i = 1'b0;
                    in_base_i = ~in_base_i; k_len_i = ~k_len_i; out_base_i = ~out_base_i;
                end
                chk({tag, "/err_c1"}, err_o, 32'(!valid));
                chk({tag, "/done_c1"}, done_o, 32'(!valid));
                if (valid) begin
                    chk({tag, "/first_rd_req"}, mem_if.req, 1);
                    chk({tag, "/first_rd_addr"}, mem_if.addr, kb);
                end
            end
            if (valid && c == 2 * k + 1) begin
                chk({tag, "/first_wr_we"}, mem_if.we, 1);
                chk({tag, "/first_wr_addr"}, mem_if.addr, ob);
            end
            if (!ext_gnt_o) gnt_low++;
            if (mem_if.req) reqs++;
            if (running_e_o) re_cnt++;
            if (done_e_o) begin lat = c; break; end
        end
        chk({tag, "/done_latency"}, lat, t_exp);
        chk({tag, "/gnt_low_cycles"}, gnt_low, t_exp - 1);
        chk({tag, "/sram_reqs"}, reqs, valid ? t_exp - 1 : 0);
        chk({tag, "/running_e_pulses"}, re_cnt, 32'(valid));
        chk({tag, "/err_end"}, err_o, 32'(!valid));
        chk({tag, "/done_end"}, done_o, 1);
        chk({tag, "/running_end"}, running_o, 0);
        if (valid) for (int j = 0; j < m; j++) chk({tag, "/out_word"}, sram[ob+j], exp_out[j]);
        if (hold) begin
            @(negedge clk);
            chk({tag, "/restart_accept"}, running_e_o, 1);
            start_i = 1'b0;
            wait_done({tag, "/second"}, lat);
            chk({tag, "/second_latency"}, lat, t_exp - 1);
            chk({tag, "/second_out0"}, sram[ob], exp_out[0]);
        end else begin
            @(negedge clk);
            chk({tag, "/done_e_single"}, done_e_o, 0);
        end
    endtask

    task automatic chk_reset_outputs(string tag);
        chk({tag, "/ext_gnt"}, ext_gnt_o, 1);
        chk({tag, "/req"}, mem_if.req, 0);
        chk({tag, "/we"}, mem_if.we, 0);
        chk({tag, "/addr"}, mem_if.addr, 0);
        chk({tag, "/wdata"}, mem_if.wdata, 0);
        chk({tag, "/status"}, {running_o, running_e_o, done_o, done_e_o, err_o}, 0);
    endtask

    initial begin
        int k, n, ib, kb, ob, m;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_ni = 1'b1;

        // Directed: N=8 ramp, kernel [1,0,-1] -> all -2, done_e at cycle 28.
        for (int i = 0; i < 8; i++) vin[i] = i + 1;
        vk[0] = 1; vk[1] = 0; vk[2] = -1;
        load_mem(0, 8, 16, 3);
        run_job("k3n8", 0, 8, 16, 3, 32, 1'b0);
        chk("k3n8/word32", sram[32], 32'hFFFF_FFFE);

        // Directed: K=1 scaling.
        for (int i = 0; i < 4; i++) vin[i] = i + 1;
        vk[0] = 5;
        load_mem(0, 4, 16, 1);
        run_job("k1n4", 0, 4, 16, 1, 48, 1'b0);
        chk("k1n4/word51", sram[51], 20);

        // Invalid configurations, each followed by a recovering valid job.
        run_job("inv_k0", 0, 4, 16, 0, 48, 1'b0);
        run_job("rec_k0", 0, 4, 16, 1, 48, 1'b0);
        run_job("inv_k_gt_n", 0, 3, 16, 4, 48, 1'b0);
        run_job("rec_kn", 0, 4, 16, 1, 48, 1'b0);
        run_job("inv_out_ovf", 0, 3, 16, 1, 126, 1'b0);
        run_job("rec_ovf", 0, 4, 16, 1, 48, 1'b0);

        // Wrap-around of the accumulator.
        vin[0] = 32'h7FFF_FFFF; vin[1] = 1; vk[0] = 1; vk[1] = 1;
        load_mem(0, 2, 16, 2);
        run_job("wrap", 0, 2, 16, 2, 48, 1'b0);

        // Randomized jobs with disjoint regions.
        for (int t = 0; t < 6; t++) begin
            k  = $urandom_range(1, 8);
            n  = $urandom_range(k, k + 12);
            ib = $urandom_range(0, 40 - n);
            kb = $urandom_range(40, 56);
            m  = n - k + 1;
            ob = $urandom_range(64, 128 - m);
            for (int i = 0; i < n; i++) vin[i] = $urandom;
            for (int i = 0; i < k; i++) vk[i] = $urandom;
            load_mem(ib, n, kb, k);
            run_job("rand", ib, n, kb, k, ob, 1'b0);
        end

        // Reset five cycles into a job, then a full job.
        for (int i = 0; i < 8; i++) vin[i] = i + 1;
        vk[0] = 1; vk[1] = 0; vk[2] = -1;
        load_mem(0, 8, 16, 3);
        @(negedge clk);
        in_base_i = 7'd0; in_len_i = 8'd8; k_base_i = 7'd16; k_len_i = 4'd3; out_base_i = 7'd32;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (4) @(negedge clk);
        chk("midjob/running", running_o, 1);
        #2 rst_ni = 1'b0;
        #1 chk_reset_outputs("midjob_reset");
        @(negedge clk);
        rst_ni = 1'b1;
        run_job("after_reset", 0, 8, 16, 3, 32, 1'b0);

        // start_i held high across a whole job.
        run_job("held_start", 0, 8, 16, 3, 32, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
